seq_stage_ctrl: RTL and testbench
=================================

# seq_stage_ctrl

Multi-cycle stage sequencer for the SEQ Y86-64 core. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, and drives one enable per stage. It gates condition-code updates, runs the data-memory request/acknowledge handshake with a timeout, and tracks processor status (AOK/HLT/ADR/INS). It also keeps cycle and retired-instruction counters.

## Interface
- `MEM_TIMEOUT`, 15: maximum MEMORY-state cycles waiting for `mem_ack` before an ADR fault (≥1).
- `CNT_W`, 32: width of `cycle_cnt` and `instr_cnt`.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: leave IDLE and begin fetching.
- `icode` in 4: instruction code from fetch; sampled in FETCH when `instr_valid`=1.
- `instr_valid` in 1: fetch output valid this cycle.
- `imem_error` in 1: instruction-memory address fault.
- `mem_ack` in 1: data memory completed the access.
- `dmem_error` in 1: data-memory fault; sampled only with `mem_ack`=1.
- `fetch_en`, `decode_en`, `exe_en`, `mem_en`, `wb_en`, `pc_en` out 1 each: stage enables.
- `set_cc` out 1: condition-code register write enable.
- `mem_req` out 1: data-memory request.
- `stat` out 3: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `halted` out 1: core stopped.
- `cycle_cnt` out CNT_W: active cycles.
- `instr_cnt` out CNT_W: retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Moore enables: exactly one `*_en` is high in FETCH..PCUPD. All enables are 0 in IDLE and HALT.
- IDLE: stays until `start`=1, then goes to FETCH.
- FETCH checks are evaluated every cycle, in priority order:
  - `imem_error` → `stat`=ADR, go to HALT.
  - else `instr_valid`=0 → stay in FETCH.
  - else `icode`>11 → `stat`=INS, go to HALT.
  - else `icode`=0 → `stat`=HLT, `instr_cnt`+1, go to HALT.
  - else latch `icode` internally (`icode_q`) and go to DECODE.
- DECODE → EXECUTE, unconditionally.
- EXECUTE: `set_cc`=1 iff `icode_q`=6 (OPq), for this single cycle.
  - Next state is MEMORY if `icode_q` ∈ {4,5,8,9,10,11}, else WRITEBACK.
- MEMORY: `mem_req`=1 while in this state. An internal wait counter resets to 0 on entry.
  - `mem_ack`=1 and `dmem_error`=1 → `stat`=ADR, go to HALT.
  - `mem_ack`=1 and `dmem_error`=0 → go to WRITEBACK.
  - No ack on the MEM_TIMEOUT-th MEMORY cycle → `stat`=ADR, go to HALT.
- WRITEBACK → PCUPD.
- PCUPD: `instr_cnt`+1, go to FETCH.
- HALT: absorbing; `halted`=1. `start` is ignored; only `reset` exits.
- `cycle_cnt` increments in every cycle spent in FETCH..PCUPD.
- Counter rules: both counters wrap modulo 2^CNT_W. Faulting instructions (ADR, INS) do not increment `instr_cnt`.
- `stat` changes only on the HALT transition.

## Timing
- Reset values, registered next edge: state=IDLE, `stat`=1, `halted`=0, counters=0, `icode_q`=0. Consequently all enables, `set_cc` and `mem_req` are 0.
- `reset` overrides every other input in every state, including mid-MEMORY. `mem_req` drops on the cycle after the reset edge.
- Instruction latency with no memory access and `instr_valid` high in the first FETCH cycle: 5 cycles.
- With a memory access, latency is 5 + k cycles, where the ack arrives in MEMORY cycle k (1 ≤ k ≤ MEM_TIMEOUT).
- An ack in the same cycle `mem_req` rises is accepted (k=1).
- `mem_ack` outside MEMORY is ignored.
- `stat` and `halted` update together on the same edge that enters HALT.

## Test plan
- **OPq (`icode`=6).** Stimulus: reset, `start`, `instr_valid`=1. Response: enables fetch→decode→exe→wb→pc on 5 consecutive cycles; `set_cc`=1 only in the exe cycle; afterwards `instr_cnt`=1, `cycle_cnt`=5.
- **mrmovq (`icode`=5) with delayed ack.** Stimulus: `mem_ack` on the 3rd MEMORY cycle. Response: `mem_req` high for 3 cycles; 8 cycles total; `set_cc` never 1; `stat`=1.
- **halt (`icode`=0).** Response: HALT next cycle, `stat`=2, `halted`=1, `instr_cnt`=1. A later `start` pulse leaves state, counters and outputs unchanged.
- **Invalid opcode (`icode`=12).** Response: `stat`=4, `instr_cnt`=0. Repeat with `imem_error`=1 and `icode`=12 together → `stat`=3 (error priority).
- **ret (`icode`=9) with no ack, MEM_TIMEOUT=15.** Response: `mem_req` high exactly 15 cycles, then `stat`=3, `halted`=1. Repeat with ack on cycle 15 and `dmem_error`=1 → `stat`=3.
- **Reset mid-MEMORY.** Stimulus: `reset` pulse on the 2nd MEMORY cycle. Response: after the edge, all enables and `mem_req` are 0, `stat`=1, counters 0, state IDLE; a following `start` resumes normal fetch.

Source files
------------

// File: rtl/seq_stage_ctrl_if.sv
// Fetch-status and data-memory handshake bundle between the SEQ stage sequencer
// (master) and the fetch/data-memory side of the datapath (slave).
interface seq_stage_ctrl_if;
    logic [3:0] icode;
    logic       instr_valid;
    logic       imem_error;
    logic       mem_req;
    logic       mem_ack;
    logic       dmem_error;

    modport master (
        input  icode,
        input  instr_valid,
        input  imem_error,
        input  mem_ack,
        input  dmem_error,
        output mem_req
    );

    modport slave (
        output icode,
        output instr_valid,
        output imem_error,
        output mem_ack,
        output dmem_error,
        input  mem_req
    );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the SEQ Y86-64 core: one-hot stage enables,
// CC write gating, data-memory handshake with timeout, status and counters.
module seq_stage_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    seq_stage_ctrl_if.master bus,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             set_cc,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT = 4'd0;
    localparam logic [3:0] ICODE_OPQ  = 4'd6;
    localparam logic [3:0] ICODE_MAX  = 4'd11;

    // Enable vector bit order: {pc, wb, mem, exe, decode, fetch}
    localparam logic [5:0] EN_NONE   = 6'b000000;
    localparam logic [5:0] EN_FETCH  = 6'b000001;
    localparam logic [5:0] EN_DECODE = 6'b000010;
    localparam logic [5:0] EN_EXE    = 6'b000100;
    localparam logic [5:0] EN_MEM    = 6'b001000;
    localparam logic [5:0] EN_WB     = 6'b010000;
    localparam logic [5:0] EN_PC     = 6'b100000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    // Instructions that need a data-memory access: rmmovq, mrmovq, call, ret, pushq, popq.
    function automatic logic icode_uses_dmem(input logic [3:0] code);
        logic uses;
        case (code)
            4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: uses = 1'b1;
            default:                              uses = 1'b0;
        endcase
        return uses;
    endfunction

    function automatic logic state_is_active(input state_t st);
        logic active;
        case (st)
            ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_PCUPD: active = 1'b1;
            default:                                                          active = 1'b0;
        endcase
        return active;
    endfunction

    function automatic logic [5:0] state_enables(input state_t st);
        logic [5:0] en;
        case (st)
            ST_FETCH:     en = EN_FETCH;
            ST_DECODE:    en = EN_DECODE;
            ST_EXECUTE:   en = EN_EXE;
            ST_MEMORY:    en = EN_MEM;
            ST_WRITEBACK: en = EN_WB;
            ST_PCUPD:     en = EN_PC;
            default:      en = EN_NONE;
        endcase
        return en;
    endfunction

    state_t            state_q,     state_d;
    logic [3:0]        icode_q,     icode_d;
    logic [2:0]        stat_q,      stat_d;
    logic [WAIT_W-1:0] wait_q,      wait_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
    logic [5:0]        en_q,        en_d;
    logic              set_cc_q,    set_cc_d;
    logic              mem_req_q,   mem_req_d;
    logic              halted_q,    halted_d;

    // Next-state, status and counter computation.
    always_comb begin
        state_d     = state_q;
        icode_d     = icode_q;
        stat_d      = stat_q;
        wait_d      = wait_q;
        instr_cnt_d = instr_cnt_q;
        if (state_is_active(state_q)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = ST_HALT;
                end else if (!bus.instr_valid) begin
                    state_d = ST_FETCH;
                end else if (bus.icode > ICODE_MAX) begin
                    stat_d  = STAT_INS;
                    state_d = ST_HALT;
                end else if (bus.icode == ICODE_HALT) begin
                    // halt retires normally even though it stops the core
                    stat_d      = STAT_HLT;
                    instr_cnt_d = instr_cnt_q + CNT_ONE;
                    state_d     = ST_HALT;
                end else begin
                    icode_d = bus.icode;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (icode_uses_dmem(icode_q)) begin
                    wait_d  = WAIT_ZERO;
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (bus.mem_ack) begin
                    if (bus.dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    stat_d  = STAT_ADR;
                    state_d = ST_HALT;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_PCUPD;
            end
            ST_PCUPD: begin
                instr_cnt_d = instr_cnt_q + CNT_ONE;
                state_d     = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the outputs come straight from flops.
    always_comb begin
        en_d      = state_enables(state_d);
        set_cc_d  = (state_d == ST_EXECUTE) && (icode_q == ICODE_OPQ);
        mem_req_d = (state_d == ST_MEMORY);
        halted_d  = (state_d == ST_HALT);
    end

    // State, status, counter and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            icode_q     <= 4'd0;
            stat_q      <= STAT_AOK;
            wait_q      <= WAIT_ZERO;
            cycle_cnt_q <= CNT_ZERO;
            instr_cnt_q <= CNT_ZERO;
            en_q        <= EN_NONE;
            set_cc_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            icode_q     <= icode_d;
            stat_q      <= stat_d;
            wait_q      <= wait_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            en_q        <= en_d;
            set_cc_q    <= set_cc_d;
            mem_req_q   <= mem_req_d;
            halted_q    <= halted_d;
        end
    end

    assign fetch_en    = en_q[0];
    assign decode_en   = en_q[1];
    assign exe_en      = en_q[2];
    assign mem_en      = en_q[3];
    assign wb_en       = en_q[4];
    assign pc_en       = en_q[5];
    assign set_cc      = set_cc_q;
    assign bus.mem_req = mem_req_q;
    assign stat        = stat_q;
    assign halted      = halted_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instr_cnt   = instr_cnt_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Randomized instruction-level bench for seq_stage_ctrl: a per-instruction stage
// schedule model predicts enables, handshake, status and counters every cycle.
module tb_seq_stage_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 32;

    localparam int S_NONE = -1;
    localparam int S_F    = 0;
    localparam int S_D    = 1;
    localparam int S_E    = 2;
    localparam int S_M    = 3;
    localparam int S_W    = 4;
    localparam int S_P    = 5;

    // run_instr outcomes
    localparam int R_RETIRED = 0;
    localparam int R_HALTED  = 1;
    localparam int R_RESET   = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             fetch_en, decode_en, exe_en, mem_en, wb_en, pc_en;
    logic             set_cc;
    logic [2:0]       stat;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    seq_stage_ctrl_if bus ();

    seq_stage_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .fetch_en  (fetch_en),
        .decode_en (decode_en),
        .exe_en    (exe_en),
        .mem_en    (mem_en),
        .wb_en     (wb_en),
        .pc_en     (pc_en),
        .set_cc    (set_cc),
        .stat      (stat),
        .halted    (halted),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model of architecturally visible state
    int exp_cycles;
    int exp_instr;
    int exp_stat;
    int exp_halted;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Drive don't-care values on inputs the current stage must ignore.
    task automatic noise();
        bus.mem_ack     = 1'($urandom_range(0, 1));
        bus.dmem_error  = 1'($urandom_range(0, 1));
        bus.icode       = 4'($urandom_range(0, 15));
        bus.instr_valid = 1'($urandom_range(0, 1));
        bus.imem_error  = 1'b0;
    endtask

    task automatic check_cycle(input string tag, input int stage, input int ic);
        logic [5:0] exp_en;
        exp_en = (stage < 0) ? 6'd0 : 6'(1 << stage);
        check_eq({tag, "/en"}, 64'({pc_en, wb_en, mem_en, exe_en, decode_en, fetch_en}), 64'(exp_en));
        check_eq({tag, "/mem_req"}, 64'(bus.mem_req), 64'(stage == S_M));
        check_eq({tag, "/set_cc"}, 64'(set_cc), 64'(stage == S_E && ic == 6));
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "/stat"}, 64'(stat), 64'(exp_stat));
        check_eq({tag, "/halted"}, 64'(halted), 64'(exp_halted));
        check_eq({tag, "/cycle_cnt"}, 64'(cycle_cnt), 64'(exp_cycles));
        check_eq({tag, "/instr_cnt"}, 64'(instr_cnt), 64'(exp_instr));
    endtask

    task automatic model_reset();
        exp_cycles = 0;
        exp_instr  = 0;
        exp_stat   = 1;
        exp_halted = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        noise();
        step();
        reset = 1'b0;
        model_reset();
        check_cycle("reset", S_NONE, 0);
        check_status("reset");
    endtask

    task automatic do_start();
        check_cycle("idle", S_NONE, 0);
        start = 1'b1;
        noise();
        step();
        start = 1'b0;
    endtask

    // In HALT nothing moves, even with start pulsed and inputs wiggling.
    task automatic enter_halt(input int st);
        exp_stat   = st;
        exp_halted = 1;
        check_cycle("halt", S_NONE, 0);
        check_status("halt");
        start = 1'b1;
        noise();
        step();
        start = 1'b0;
        noise();
        step();
        check_cycle("halt_start", S_NONE, 0);
        check_status("halt_start");
    endtask

    // One instruction from its first FETCH cycle. k = ack cycle (0 = never),
    // rst_at = MEMORY cycle on which reset is pulsed (0 = never).
    task automatic run_instr(input int ic, input int delay, input int k, input bit derr,
                             input bit ierr, input int rst_at, output int result);
        for (int i = 0; i < delay; i++) begin
            check_cycle("fetch_wait", S_F, ic);
            noise();
            bus.instr_valid = 1'b0;
            exp_cycles++;
            step();
        end
        check_cycle("fetch", S_F, ic);
        noise();
        bus.instr_valid = 1'b1;
        bus.icode       = 4'(ic);
        bus.imem_error  = ierr;
        exp_cycles++;
        step();
        if (ierr) begin
            enter_halt(3);
            result = R_HALTED;
            return;
        end
        if (ic > 11) begin
            enter_halt(4);
            result = R_HALTED;
            return;
        end
        if (ic == 0) begin
            exp_instr++;
            enter_halt(2);
            result = R_HALTED;
            return;
        end
        check_cycle("decode", S_D, ic);
        noise();
        exp_cycles++;
        step();
        check_cycle("execute", S_E, ic);
        noise();
        exp_cycles++;
        step();
        if (ic inside {4, 5, 8, 9, 10, 11}) begin
            for (int c = 1; c <= MEM_TIMEOUT; c++) begin
                check_cycle("memory", S_M, ic);
                check_status("memory");
                exp_cycles++;
                if (c == rst_at) begin
                    reset = 1'b1;
                    noise();
                    step();
                    reset = 1'b0;
                    model_reset();
                    check_cycle("mid_mem_reset", S_NONE, 0);
                    check_status("mid_mem_reset");
                    result = R_RESET;
                    return;
                end
                noise();
                bus.mem_ack = (c == k);
                if (c == k) begin
                    bus.dmem_error = derr;
                end
                step();
                if (c == k) begin
                    if (derr) begin
                        enter_halt(3);
                        result = R_HALTED;
                        return;
                    end
                    break;
                end
                if (c == MEM_TIMEOUT) begin
                    enter_halt(3);
                    result = R_HALTED;
                    return;
                end
            end
        end
        check_cycle("writeback", S_W, ic);
        noise();
        exp_cycles++;
        step();
        check_cycle("pcupd", S_P, ic);
        noise();
        exp_cycles++;
        exp_instr++;
        step();
        check_status("retired");
        result = R_RETIRED;
    endtask

    initial begin
        int res;
        int ic;
        int k;
        bit derr;
        bit ierr;
        int sel;

        reset = 1'b1;
        start = 1'b0;
        bus.icode       = 4'd0;
        bus.instr_valid = 1'b0;
        bus.imem_error  = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.dmem_error  = 1'b0;
        @(negedge clock);
        do_reset();

        // OPq then mrmovq with ack on the 3rd MEMORY cycle
        do_start();
        run_instr(6, 0, 0, 1'b0, 1'b0, 0, res);
        check_eq("opq_cycles", 64'(cycle_cnt), 64'd5);
        run_instr(5, 0, 3, 1'b0, 1'b0, 0, res);
        check_eq("mrmovq_cycles", 64'(cycle_cnt), 64'd13);

        // halt, invalid opcode, and imem_error priority over the invalid opcode
        do_reset();
        do_start();
        run_instr(0, 0, 0, 1'b0, 1'b0, 0, res);
        do_reset();
        do_start();
        run_instr(12, 0, 0, 1'b0, 1'b0, 0, res);
        do_reset();
        do_start();
        run_instr(12, 1, 0, 1'b0, 1'b1, 0, res);

        // ret timeout, then ret with a faulting ack on the last allowed cycle
        do_reset();
        do_start();
        run_instr(9, 0, 0, 1'b0, 1'b0, 0, res);
        do_reset();
        do_start();
        run_instr(9, 0, MEM_TIMEOUT, 1'b1, 1'b0, 0, res);

        // accepted ack exactly on the last allowed cycle, then ack on the first cycle
        do_reset();
        do_start();
        run_instr(8, 2, MEM_TIMEOUT, 1'b0, 1'b0, 0, res);
        run_instr(10, 0, 1, 1'b0, 1'b0, 0, res);

        // reset on the 2nd MEMORY cycle, then normal resumption
        run_instr(5, 0, 0, 1'b0, 1'b0, 2, res);
        do_start();
        run_instr(6, 1, 0, 1'b0, 1'b0, 0, res);

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            sel  = $urandom_range(0, 99);
            ierr = 1'b0;
            if (sel < 4) begin
                ic = 0;
            end else if (sel < 8) begin
                ic = $urandom_range(12, 15);
            end else begin
                ic = $urandom_range(1, 11);
                ierr = (sel < 11);
            end
            sel  = $urandom_range(0, 99);
            derr = (sel < 8);
            k    = (sel >= 8 && sel < 16) ? 0 : $urandom_range(1, MEM_TIMEOUT);
            run_instr(ic, $urandom_range(0, 3), k, derr, ierr, 0, res);
            if (res == R_HALTED) begin
                do_reset();
                do_start();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
